// File: rtl/noekeon_pkg.sv
// Shared Noekeon definitions: word layout, round constants, FSM/mode
// encodings and the Theta/Gamma/Pi transformations on a 128-bit block.
package noekeon_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int NUM_WORDS = 4;
  localparam int RC_IDX_W  = 5;

  // Word positions inside a block: a0 is the most significant word.
  localparam int A0_LSB = 96;
  localparam int A1_LSB = 64;
  localparam int A2_LSB = 32;
  localparam int A3_LSB = 0;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Round constant RC[idx], zero-extended into the low byte of a word.
  function automatic word_t rc_word(input logic [RC_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'h80;
      5'd1:    b = 8'h1B;
      5'd2:    b = 8'h36;
      5'd3:    b = 8'h6C;
      5'd4:    b = 8'hD8;
      5'd5:    b = 8'hAB;
      5'd6:    b = 8'h4D;
      5'd7:    b = 8'h9A;
      5'd8:    b = 8'h2F;
      5'd9:    b = 8'h5E;
      5'd10:   b = 8'hBC;
      5'd11:   b = 8'h63;
      5'd12:   b = 8'hC6;
      5'd13:   b = 8'h97;
      5'd14:   b = 8'h35;
      5'd15:   b = 8'h6A;
      5'd16:   b = 8'hD4;
      default: b = 8'h00;
    endcase
    return {24'h0, b};
  endfunction

  function automatic word_t rotl(input word_t w, input int unsigned n);
    return (w << n) | (w >> (WORD_W - n));
  endfunction

  function automatic word_t rotr(input word_t w, input int unsigned n);
    return (w >> n) | (w << (WORD_W - n));
  endfunction

  function automatic block_t xor_a0(input block_t b, input word_t c);
    block_t r;
    r = b;
    r[A0_LSB +: WORD_W] = b[A0_LSB +: WORD_W] ^ c;
    return r;
  endfunction

  function automatic block_t theta(input block_t k, input block_t a);
    word_t a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = a;
    t  = a0 ^ a2;
    t  = t ^ rotr(t, 8) ^ rotl(t, 8);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[A0_LSB +: WORD_W];
    a1 = a1 ^ k[A1_LSB +: WORD_W];
    a2 = a2 ^ k[A2_LSB +: WORD_W];
    a3 = a3 ^ k[A3_LSB +: WORD_W];
    t  = a1 ^ a3;
    t  = t ^ rotr(t, 8) ^ rotl(t, 8);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic block_t gamma(input block_t a);
    word_t a0, a1, a2, a3, tmp;
    {a0, a1, a2, a3} = a;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    tmp = a3;
    a3  = a0;
    a0  = tmp;
    a2  = a2 ^ a0 ^ a1 ^ a3;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic block_t pi1(input block_t a);
    word_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {a0, rotl(a1, 1), rotl(a2, 5), rotl(a3, 2)};
  endfunction

  function automatic block_t pi2(input block_t a);
    word_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {a0, rotr(a1, 1), rotr(a2, 5), rotr(a3, 2)};
  endfunction

endpackage

// File: rtl/noekeon_round.sv
// One combinational Noekeon round: Round(K, a, c1, c2).
module noekeon_round
  import noekeon_pkg::*;
(
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [WORD_W-1:0]  c1_i,
  input  logic [WORD_W-1:0]  c2_i,
  output logic [BLOCK_W-1:0] state_o
);

  block_t s_c1, s_th, s_c2, s_p1, s_g;

  assign s_c1    = xor_a0(state_i, c1_i);
  assign s_th    = theta(key_i, s_c1);
  assign s_c2    = xor_a0(s_th, c2_i);
  assign s_p1    = pi1(s_c2);
  assign s_g     = gamma(s_p1);
  assign state_o = pi2(s_g);

endmodule

// File: rtl/noekeon_round_core.sv
// Iterative Noekeon engine in direct-key mode: one round per clock,
// then a final Theta step, result presented with a one-cycle done strobe.
module noekeon_round_core
  import noekeon_pkg::*;
#(
  parameter int NR = 16
) (
  input  logic               inClk,
  input  logic               inReset,
  input  logic               inStart,
  input  logic               inDecrypt,
  input  logic [BLOCK_W-1:0] inData,
  input  logic [BLOCK_W-1:0] inKey,
  output logic               outBusy,
  output logic               outDone,
  output logic [BLOCK_W-1:0] outData
);

  localparam int CNT_W = $clog2(NR);

  state_e             fsm_q, fsm_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  block_t             blk_q, blk_d;
  block_t             key_q, key_d;
  block_t             data_q, data_d;
  logic               done_q, done_d;

  word_t              c1, c2;
  block_t             round_out, final_enc, final_dec;

  // Encrypt walks RC[0..15] on c1; decrypt walks RC[16..1] on c2.
  assign c1 = (mode_q == MODE_ENC) ? rc_word(RC_IDX_W'(cnt_q)) : '0;
  assign c2 = (mode_q == MODE_DEC) ? rc_word(RC_IDX_W'(NR) - RC_IDX_W'(cnt_q)) : '0;

  noekeon_round u_round (
    .key_i   (key_q),
    .state_i (blk_q),
    .c1_i    (c1),
    .c2_i    (c2),
    .state_o (round_out)
  );

  assign final_enc = theta(key_q, xor_a0(blk_q, rc_word(RC_IDX_W'(NR))));
  assign final_dec = xor_a0(theta(key_q, blk_q), rc_word('0));

  // Next-state and datapath selection for IDLE / RUN / FINAL.
  always_comb begin
    fsm_d  = fsm_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    key_d  = key_q;
    data_d = data_q;
    done_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (inStart) begin
          blk_d  = inData;
          key_d  = inDecrypt ? theta('0, inKey) : inKey;
          mode_d = inDecrypt ? MODE_DEC : MODE_ENC;
          cnt_d  = '0;
          fsm_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        blk_d = round_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NR - 1)) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        data_d = (mode_q == MODE_DEC) ? final_dec : final_enc;
        done_d = 1'b1;
        fsm_d  = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State register; reset clears control and datapath alike.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      fsm_q  <= ST_IDLE;
      mode_q <= MODE_ENC;
      cnt_q  <= '0;
      blk_q  <= '0;
      key_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      key_q  <= key_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign outBusy = (fsm_q != ST_IDLE);
  assign outDone = done_q;
  assign outData = data_q;

endmodule

// File: doc/noekeon_round_core.md
Name: noekeon_round_core

Overview:
- Iterative Noekeon cipher engine, one round per clock, consuming the 128-bit key held by the key register (its outKey feeds inKey here).
- Accepts a 128-bit data block with a start strobe and encrypts or decrypts it in direct-key mode.
- Returns the result with a one-cycle write strobe; the strobe/data pair can drive the key register's internal write port or the host output path.

Parameters:
- NR, 16, number of full rounds; fixed by the algorithm; other values unsupported.

Ports:
- inClk  input  1  clock, all state on rising edge.
- inReset  input  1  synchronous, active-high reset.
- inStart  input  1  start request; sampled only in IDLE.
- inDecrypt  input  1  mode, sampled with inStart: 0 = encrypt, 1 = decrypt.
- inData  input  128  plaintext or ciphertext; word a0 = [127:96] ... a3 = [31:0].
- inKey  input  128  cipher key, sampled with inStart.
- outBusy  output  1  high in RUN and FINAL.
- outDone  output  1  one-cycle pulse when outData becomes valid.
- outData  output  128  result; holds until the next accepted start.

Behaviour:
- Reset (synchronous): state = IDLE, round counter = 0, state register = 0, working key = 0, outBusy = 0, outDone = 0, outData = 0.
- Mid-operation reset aborts with no outDone.
- FSM states: IDLE, RUN, FINAL.
- IDLE, inStart = 1, accept edge:
  - Latch inData into the state register.
  - Latch the working key: inKey when encrypting; Theta(0, inKey) when decrypting.
  - Latch the mode, clear the counter, go to RUN.
- RUN: each edge applies one round to the state.
  - Encrypt, round i: const1 = RC[i], const2 = 0.
  - Decrypt, round i: const1 = 0, const2 = RC[16 - i].
  - After NR rounds (counter 15 -> terminal), go to FINAL.
- FINAL: one edge.
  - Encrypt: a0 ^= RC[16], then Theta(K, state).
  - Decrypt: Theta(K', state), then a0 ^= RC[0].
  - Result goes to outData; outDone = 1 for exactly that following cycle; return to IDLE.
- Latency: start accepted at edge 0; outDone high in the cycle after edge 17. Back-to-back: a new start is accepted in the outDone cycle.
- inStart while outBusy: ignored. No queueing, no error.
- inKey/inData changes after acceptance: no effect.
- Round(K, a, c1, c2) =
  - a0 ^= c1; Theta(K, a); a0 ^= c2;
  - Pi1: a1 <<<1, a2 <<<5, a3 <<<2;
  - Gamma;
  - Pi2: a1 >>>1, a2 >>>5, a3 >>>2.
- Theta(K, a):
  - t = a0^a2; t ^= (t>>>8)^(t<<<8); a1 ^= t; a3 ^= t;
  - ai ^= Ki;
  - t = a1^a3; t ^= (t>>>8)^(t<<<8); a0 ^= t; a2 ^= t.
- Gamma:
  - a1 ^= ~a3&~a2; a0 ^= a2&a1;
  - swap a0, a3;
  - a2 ^= a0^a1^a3;
  - a1 ^= ~a3&~a2; a0 ^= a2&a1.
- All arithmetic is 32-bit bitwise and rotates; no carries.
- RC[0..16]: 80 1B 36 6C D8 AB 4D 9A 2F 5E BC 63 C6 97 35 6A D4, zero-extended into bits [7:0] of the 32-bit word.

Decomposition:
- Shared package:
  - RC table (17 x 8 bit).
  - Word-slicing constants.
  - Functions theta, gamma, pi1, pi2.
  - Mode encoding and FSM state encoding.
- Sub-module noekeon_round: combinational Round(K, a, c1, c2).
  - Instantiated once and shared by encrypt and decrypt.
  - The FINAL step reuses the package theta.

Test Plan:
- Reset with all inputs 0 -> outData = 0, outBusy = 0, outDone = 0.
- Encrypt, key 0, data 0, start -> outBusy high 17 cycles; outDone pulse; outData = b1656851699e29fa24b70148503d2dfc.
- Encrypt, key all-F, data all-F -> outData = 2a78421b87c7d0924f26113f1d1349b2.
- Encrypt, key b1656851699e29fa24b70148503d2dfc, data 2a78421b87c7d0924f26113f1d1349b2 -> e2f687e07b75660ffc372233bc47532c. Then decrypt the same key on that output -> 2a78421b87c7d0924f26113f1d1349b2.
- Start asserted again at cycles 3 and 10 of an operation -> ignored; single outDone at cycle 18. Start in the outDone cycle -> second operation accepted, outDone 17 cycles later.
- inReset at cycle 8 mid-operation -> next cycle IDLE, outData = 0, no outDone. A fresh start then gives the correct vector.
